// File: rtl/prost_sbox_layer_ctrl_if.sv
// Bundle of the scheduler's control, state and S-box/randomness ports.
// slave: the scheduler itself. master: round controller, randomness source and S-box.
interface prost_sbox_layer_ctrl_if #(
  parameter int NIBBLES = 16,
  parameter int RAN_W   = 8
);
  logic                   start;
  logic [4*NIBBLES-1:0]   state0_in;
  logic [4*NIBBLES-1:0]   state1_in;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   state0_out;
  logic [4*NIBBLES-1:0]   state1_out;
  logic                   ran_valid;
  logic                   ran_ready;
  logic [RAN_W-1:0]       ran_in;
  logic [3:0]             sb_in0;
  logic [3:0]             sb_in1;
  logic [RAN_W-1:0]       sb_ran;
  logic [3:0]             sb_out0;
  logic [3:0]             sb_out1;

  modport master (
    output start, state0_in, state1_in, ran_valid, ran_in, sb_out0, sb_out1,
    input  busy, done, state0_out, state1_out, ran_ready, sb_in0, sb_in1, sb_ran
  );

  modport slave (
    input  start, state0_in, state1_in, ran_valid, ran_in, sb_out0, sb_out1,
    output busy, done, state0_out, state1_out, ran_ready, sb_in0, sb_in1, sb_ran
  );
endinterface

// File: rtl/prost_sbox_layer_ctrl.sv
// Nibble-serial scheduler for a 2-share masked PROST S-box layer.
// Feeds one nibble pair plus fresh randomness per issue slot into a single
// external S-box, tracks results through an SBOX_LAT-deep valid pipe and
// reassembles both output shares in separate registers.
// Optional build macro PROST_CTRL_BUBBLE_EN: forces an idle cycle at the
// S-box inputs after every issue so consecutive nibbles never follow each
// other directly.
module prost_sbox_layer_ctrl #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1,
  parameter int RAN_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  prost_sbox_layer_ctrl_if.slave  bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [IW-1:0]       LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [SBOX_LAT-1:0] TAIL_BIT = SBOX_LAT'(1) << (SBOX_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_iss_idx;
  logic [IW-1:0]       r_cap_idx;
  logic [SBOX_LAT-1:0] r_vld_p1;
  logic                r_busy;
  logic                r_done;
  logic [W-1:0]        r_sh0_p0;
  logic [W-1:0]        r_sh1_p0;
  logic [W-1:0]        r_out0;
  logic [W-1:0]        r_out1;

  logic w_slot;
  logic w_issue;
  logic w_tail;
  logic w_more;

`ifdef PROST_CTRL_BUBBLE_EN
  logic r_bubble;
  // A pending bubble blocks the slot; it is only spent on a cycle with randomness available
  assign w_slot = bus.ran_valid && !r_bubble;
`else
  assign w_slot = bus.ran_valid;
`endif

  assign w_issue = (r_state == S_RUN) && w_slot;
  assign w_tail  = r_vld_p1[SBOX_LAT-1];
  // Results still in flight behind the one being captured this cycle
  assign w_more  = |(r_vld_p1 & ~TAIL_BIT);

  assign bus.ran_ready  = w_issue;
  assign bus.sb_in0     = w_issue ? r_sh0_p0[3:0] : 4'h0;
  assign bus.sb_in1     = w_issue ? r_sh1_p0[3:0] : 4'h0;
  assign bus.sb_ran     = w_issue ? bus.ran_in : '0;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.state0_out = r_out0;
  assign bus.state1_out = r_out1;

  // Stage p0: input share shift registers, loaded on accepted start, one nibble out per issue
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_sh0_p0 <= bus.state0_in;
      r_sh1_p0 <= bus.state1_in;
    end else if (w_issue) begin
      r_sh0_p0 <= r_sh0_p0 >> 4;
      r_sh1_p0 <= r_sh1_p0 >> 4;
    end
  end

  // Stage p1: control FSM, issue/capture indices, valid pipe and output share assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_iss_idx <= '0;
      r_cap_idx <= '0;
      r_vld_p1  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_out0    <= '0;
      r_out1    <= '0;
`ifdef PROST_CTRL_BUBBLE_EN
      r_bubble  <= 1'b0;
`endif
    end else begin
      r_vld_p1 <= (r_vld_p1 << 1) | SBOX_LAT'(w_issue);
      if (w_tail) begin
        r_out0[{r_cap_idx, 2'b00} +: 4] <= bus.sb_out0;
        r_out1[{r_cap_idx, 2'b00} +: 4] <= bus.sb_out1;
        r_cap_idx <= r_cap_idx + 1'b1;
      end
      if (w_issue) begin
        r_iss_idx <= r_iss_idx + 1'b1;
      end
`ifdef PROST_CTRL_BUBBLE_EN
      if (w_issue) begin
        r_bubble <= 1'b1;
      end else if (r_state == S_RUN && bus.ran_valid) begin
        r_bubble <= 1'b0;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_out0    <= '0;
            r_out1    <= '0;
            r_iss_idx <= '0;
            r_cap_idx <= '0;
            r_vld_p1  <= '0;
`ifdef PROST_CTRL_BUBBLE_EN
            r_bubble  <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_issue && r_iss_idx == LAST_IDX) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave on the edge that captures the final result, so done and the
          // completed output state appear together
          if (!w_more) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prost_sbox_layer_ctrl.sv
`timescale 1ns/1ps
module tb_prost_sbox_layer_ctrl;
  localparam int N   = 16;
  localparam int LAT = 1;
  localparam int RW  = 8;
  localparam int W   = 4 * N;
`ifdef PROST_CTRL_BUBBLE_EN
  localparam int BASE_LAT = 2 * N - 1 + LAT;
`else
  localparam int BASE_LAT = N + LAT;
`endif
  // PROST S-box, entry i at bits [4i+3:4i]
  localparam logic [63:0] SBOX = 64'h36DBCA729E51F840;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prost_sbox_layer_ctrl_if #(.NIBBLES(N), .RAN_W(RW)) bus ();

  prost_sbox_layer_ctrl #(.NIBBLES(N), .SBOX_LAT(LAT), .RAN_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] prost_s(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX;
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] msk(input logic [RW-1:0] r);
    return r[3:0] ^ r[7:4];
  endfunction

  // Behavioural masked S-box: output shares recombine to S(x), mask from the randomness
  always @(posedge clk) begin
    bus.sb_out0 <= prost_s(bus.sb_in0 ^ bus.sb_in1) ^ msk(bus.sb_ran);
    bus.sb_out1 <= msk(bus.sb_ran);
  end

  // Randomness source: sequential pool, advances only on a handshake
  logic [RW-1:0] ran_pool [1024];
  int  rp = 0;
  bit  take = 1'b0;
  assign bus.ran_in = ran_pool[rp % 1024];
  always @(negedge clk) take = bus.ran_valid && bus.ran_ready;
  always @(posedge clk) if (take) rp <= rp + 1;

  typedef struct {
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [W-1:0] eplain;
    int           lat;
  } exp_t;
  exp_t sbq[$];

  // Monitor
  bit  active = 0, prev_busy = 0, viol = 0, hold = 0, hold_bad = 0, idle_bad = 0;
  int  cyc = 0, busy_cnt = 0, rdy_cnt = 0, spur = 0;
  logic [W-1:0] h0, h1;
  always @(negedge clk) begin
    if (rst) begin
      active = 0; hold = 0; prev_busy = 0;
    end else begin
      if (bus.busy && !prev_busy && !active) begin
        if (hold) check("outputs_stable_after_done", {63'd0, hold_bad}, 64'd0);
        hold = 0; active = 1; cyc = 0; busy_cnt = 0; rdy_cnt = 0; viol = 0;
      end else if (active) begin
        cyc++;
      end
      if (hold && (bus.state0_out !== h0 || bus.state1_out !== h1)) hold_bad = 1;
      if (active) begin
        if (bus.busy) busy_cnt++;
        if (bus.ran_ready) rdy_cnt++;
        if (!bus.ran_ready && (bus.sb_in0 != 0 || bus.sb_in1 != 0 || bus.sb_ran != 0)) viol = 1;
        if (bus.done) begin
          if (sbq.size() == 0) begin
            spur++;
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("share0", bus.state0_out, e.e0);
            check("share1", bus.state1_out, e.e1);
            check("unmasked", bus.state0_out ^ bus.state1_out, e.eplain);
            check("done_latency", cyc, e.lat);
            check("busy_cycles", busy_cnt, e.lat);
            check("ran_ready_cycles", rdy_cnt, N);
            check("sb_quiet_non_issue", {63'd0, viol}, 64'd0);
          end
          active = 0; hold = 1; hold_bad = 0;
          h0 = bus.state0_out; h1 = bus.state1_out;
        end
      end else begin
        if (bus.done) spur++;
        if (bus.ran_ready || bus.sb_in0 != 0 || bus.sb_in1 != 0 || bus.sb_ran != 0) idle_bad = 1;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic run_op(input logic [W-1:0] plain, input bit masked, input logic [31:0] stall_mask,
                        input int abort_at, input bit pulse_busy, input bit pulse_done);
    logic [W-1:0] m1, s0;
    logic [RW-1:0] r;
    exp_t e;
    int c;
    bit seen;
    m1 = masked ? {$urandom, $urandom} : '0;
    s0 = plain ^ m1;
    @(negedge clk);
    e.lat = BASE_LAT + $countones(stall_mask);
    for (int i = 0; i < N; i++) begin
      r = ran_pool[(rp + i) % 1024];
      e.e1[4*i +: 4] = msk(r);
      e.e0[4*i +: 4] = prost_s(plain[4*i +: 4]) ^ msk(r);
    end
    e.eplain = e.e0 ^ e.e1;
    bus.state0_in = s0;
    bus.state1_in = m1;
    bus.start = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 0;
    bus.ran_valid = !stall_mask[0];
    seen = 0;
    while (!seen && c < 200) begin
      @(posedge clk); #1;
      c++;
      bus.ran_valid = (c < 32) ? !stall_mask[c] : 1'b1;
      if (pulse_busy && c == 5) begin
        bus.start = 1'b1;
        bus.state0_in = {$urandom, $urandom};
        bus.state1_in = {$urandom, $urandom};
      end
      if (c == 6) bus.start = 1'b0;
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_ran_ready", {63'd0, bus.ran_ready}, 64'd0);
        check("rst_sb_in", {56'd0, bus.sb_in0, bus.sb_in1}, 64'd0);
        check("rst_sb_ran", {56'd0, bus.sb_ran}, 64'd0);
        check("rst_state0_out", bus.state0_out, 64'd0);
        check("rst_state1_out", bus.state1_out, 64'd0);
        void'(sbq.pop_back());
        @(negedge clk); #1 rst = 1'b0;
        bus.ran_valid = 1'b1;
        return;
      end
      if (bus.done) seen = 1;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    if (pulse_done) begin
      bus.start = 1'b1;
      bus.state0_in = {$urandom, $urandom};
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("start_in_done_ignored", {63'd0, bus.busy}, 64'd0);
    end
    repeat (3) begin
      @(posedge clk); #1;
      bus.ran_valid = 1'($urandom_range(0, 1));
      bus.state0_in = {$urandom, $urandom};
      bus.state1_in = {$urandom, $urandom};
    end
    bus.ran_valid = 1'b1;
  endtask

  localparam logic [W-1:0] PT0 = 64'h0123456789ABCDEF;

  initial begin
    for (int i = 0; i < 1024; i++) ran_pool[i] = RW'($urandom);
    bus.start = 1'b0;
    bus.state0_in = '0;
    bus.state1_in = '0;
    bus.ran_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_ran_ready", {63'd0, bus.ran_ready}, 64'd0);
    check("reset_sb_in", {56'd0, bus.sb_in0, bus.sb_in1}, 64'd0);
    check("reset_sb_ran", {56'd0, bus.sb_ran}, 64'd0);
    check("reset_state0_out", bus.state0_out, 64'd0);
    check("reset_state1_out", bus.state1_out, 64'd0);
    @(negedge clk); rst = 1'b0;
    bus.ran_valid = 1'b1;

    run_op(PT0, 1'b0, 32'h0, -1, 1'b0, 1'b0);
    run_op(PT0, 1'b1, 32'h0, -1, 1'b0, 1'b0);
    run_op(PT0, 1'b1, 32'h0000_00F8, -1, 1'b0, 1'b0);
    run_op({$urandom, $urandom}, 1'b1, 32'h0, -1, 1'b1, 1'b1);
    run_op({$urandom, $urandom}, 1'b1, 32'h0000_0006, 8, 1'b0, 1'b0);
    run_op(PT0, 1'b1, 32'h0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_op({$urandom, $urandom}, 1'b1, $urandom & 32'h0000_7FFF, -1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_sb_quiet", {63'd0, idle_bad}, 64'd0);
    check("spurious_done", spur, 64'd0);
    check("scoreboard_empty", sbq.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
